// File: rtl/deserialize_pkg.sv
// Shared definitions for the serial message path (deserialize / serialize).
// State encoding is common to both so their traces read the same.
package deserialize_pkg;

    localparam int MSG_SIZE_DEFAULT = 64;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

endpackage

// File: rtl/deserialize.sv
// Serial-to-parallel message assembler, MSB first, with a hold/acknowledge handshake.
// oMessage and oMessage_counter are shaped to feed serialize directly.
//
//   state | meaning
//   IDLE  | waiting for the first flagged bit of a frame
//   SHIFT | frame partially received, oBusy high
//   HOLD  | complete message presented on oMessage, waiting for iAck
module deserialize
    import deserialize_pkg::*;
#(
    parameter int MSG_SIZE = MSG_SIZE_DEFAULT
) (
    input  logic                        iClk,
    input  logic                        iRst,
    input  logic                        iEn,
    input  logic                        iSerial_in,
    input  logic                        iSerial_flag,
    input  logic                        iAck,
    output logic [MSG_SIZE-1:0]         oMessage,
    output logic [$clog2(MSG_SIZE)-1:0] oMessage_counter,
    output logic                        oValid,
    output logic                        oBusy,
    output logic                        oError
);

    localparam int CW = $clog2(MSG_SIZE);
    localparam logic [CW-1:0] LAST_IDX   = CW'(MSG_SIZE - 1);
    localparam logic [CW-1:0] PENULT_IDX = CW'(MSG_SIZE - 2);

    logic [1:0]          state;
    logic [MSG_SIZE-1:0] shiftReg;
    logic [MSG_SIZE-1:0] shiftNext;
    logic [MSG_SIZE-1:0] firstBit;

    assign shiftNext = {shiftReg[MSG_SIZE-2:0], iSerial_in};
    assign firstBit  = {{(MSG_SIZE-1){1'b0}}, iSerial_in};
    assign oBusy     = (state == SHIFT);

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            state            <= IDLE;
            shiftReg         <= '0;
            oMessage         <= '0;
            oMessage_counter <= '0;
            oValid           <= 1'b0;
            oError           <= 1'b0;
        end else begin
            // oError is a strict one-cycle pulse, even if iEn drops right after it
            oError <= 1'b0;
            if (iEn) begin
                case (state)
                    IDLE: begin
                        if (iSerial_flag) begin
                            shiftReg         <= firstBit;
                            oMessage_counter <= '0;
                            state            <= SHIFT;
                        end
                    end
                    SHIFT: begin
                        if (!iSerial_flag) begin
                            shiftReg         <= '0;
                            oMessage_counter <= '0;
                            oError           <= 1'b1;
                            state            <= IDLE;
                        end else if (oMessage_counter == PENULT_IDX) begin
                            shiftReg         <= shiftNext;
                            oMessage         <= shiftNext;
                            oMessage_counter <= LAST_IDX;
                            oValid           <= 1'b1;
                            state            <= HOLD;
                        end else begin
                            shiftReg         <= shiftNext;
                            oMessage_counter <= oMessage_counter + CW'(1);
                        end
                    end
                    HOLD: begin
                        if (iAck) begin
                            oValid <= 1'b0;
                            if (iSerial_flag) begin
                                shiftReg         <= firstBit;
                                oMessage_counter <= '0;
                                state            <= SHIFT;
                            end else begin
                                state <= IDLE;
                            end
                        end else if (iSerial_flag) begin
                            oError <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/deserialize.md
DESERIALIZE -- requirements
Module: deserialize

Interface
REQ-001 The block SHALL have parameter MSG_SIZE, default 64, giving the message width in bits; legal values are >= 2.
REQ-002 The block SHALL have port iClk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port iRst, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port iEn, input, 1 bit: sample enable; when low, the FSM and all registers hold their values.
REQ-005 The block SHALL have port iSerial_in, input, 1 bit: serial data, MSB first.
REQ-006 The block SHALL have port iSerial_flag, input, 1 bit: marks iSerial_in valid for the current cycle.
REQ-007 The block SHALL have port iAck, input, 1 bit: consumer has taken oMessage.
REQ-008 The block SHALL have port oMessage, output, MSG_SIZE bits: the assembled message.
REQ-009 The block SHALL have port oMessage_counter, output, $clog2(MSG_SIZE) bits: index of the last captured bit, MSG_SIZE-1 when the message is complete.
REQ-010 The block SHALL have port oValid, output, 1 bit: oMessage holds a complete, unacknowledged message.
REQ-011 The block SHALL have port oBusy, output, 1 bit: a frame is partially received.
REQ-012 The block SHALL have port oError, output, 1 bit: one-cycle pulse on frame abort or overrun.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, SHIFT and HOLD; all transitions require iEn=1.
REQ-014 In IDLE with iSerial_flag=1, the block SHALL shift iSerial_in into the shift-register LSB, set oMessage_counter to 0 and enter SHIFT.
REQ-015 In SHIFT with iSerial_flag=1, the block SHALL shift left, insert iSerial_in at the LSB and increment oMessage_counter.
REQ-016 The first received bit SHALL end in oMessage[MSG_SIZE-1] and the last in oMessage[0].
REQ-017 On the edge that captures bit MSG_SIZE-1, the block SHALL load oMessage, set oMessage_counter to MSG_SIZE-1, assert oValid and enter HOLD.
REQ-018 Latency from sampling the last bit to oValid SHALL be zero cycles: oValid is high immediately after that edge.
REQ-019 oMessage SHALL change only at frame completion; partial frames SHALL never be visible on it.
REQ-020 In SHIFT with iSerial_flag=0, the block SHALL discard the partial frame, pulse oError for one cycle, reset oMessage_counter to 0 and return to IDLE.
REQ-021 In HOLD, oValid SHALL stay high until iAck=1 is sampled.
REQ-022 In HOLD with iAck=1 and iSerial_flag=0, the block SHALL deassert oValid and enter IDLE on the next cycle.
REQ-023 In HOLD with iAck=1 and iSerial_flag=1, the block SHALL deassert oValid, capture the bit as the first bit of a new frame and enter SHIFT (back-to-back frames).
REQ-024 In HOLD with iAck=0 and iSerial_flag=1, the block SHALL drop the bit, pulse oError and leave oMessage and oValid unchanged (overrun).
REQ-025 oBusy SHALL equal 1 exactly when the state is SHIFT.
REQ-026 iAck outside HOLD SHALL be ignored.
REQ-027 oError SHALL be 0 in every cycle other than those defined in REQ-020 and REQ-024.

Reset
REQ-028 While iRst=0, regardless of iClk, the block SHALL force state=IDLE, oMessage=0, oMessage_counter=0, shift register=0, oValid=0, oBusy=0 and oError=0.
REQ-029 A reset asserted mid-frame or in HOLD SHALL discard all data; the first iSerial_flag after release starts a fresh frame.

Structure
REQ-030 The state encoding (IDLE, SHIFT, HOLD) and the default MSG_SIZE constant SHALL reside in a shared package, also used by serialize.
REQ-031 The block SHALL be one flat module with no sub-modules; oMessage_counter and oMessage SHALL be shaped to drive the serialize inputs iCiphertext_counter and iCiphertext directly.

Verification
REQ-032 The bench SHALL cover: MSG_SIZE=8, iEn=1, flag high for 8 cycles with bits 1,0,1,1,0,0,1,0 -> oMessage=8'hB2, oMessage_counter=7, oValid high after the 8th edge.
REQ-033 The bench SHALL cover: flag drops after 5 bits -> oError pulses 1 cycle, oBusy=0, oValid=0, oMessage unchanged.
REQ-034 The bench SHALL cover: in HOLD, flag high with iAck=0 for 3 cycles -> oError high each cycle, oMessage still 8'hB2.
REQ-035 The bench SHALL cover: iAck and the first bit of frame 8'h5A in the same cycle, followed by 7 more bits -> oValid drops for exactly 7 cycles, then oMessage=8'h5A.
REQ-036 The bench SHALL cover: iEn low for 4 cycles mid-frame -> no progress, no error; frame completes correctly after iEn returns.
REQ-037 The bench SHALL cover: iRst low for 1 cycle after bit 3 -> all outputs 0; the next 8 bits form a correct frame.
